// File: rtl/pwm_fade_sequencer.sv
// Multi-channel PWM fade sequencer: register bus, shared prescaler tick, and
// per-channel duty ramps toward software targets with sticky done flags.
`timescale 1ns/1ps
module pwm_fade_sequencer #(
    parameter int CHANNELS = 4,
    parameter int DUTY_W   = 8,
    parameter int PERIOD_W = 9,
    parameter int PRESC_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [3:0]                   addr,
    input  logic [31:0]                  wr_data,
    input  logic [3:0]                   byteenable,
    output logic [31:0]                  rd_data,
    output logic [CHANNELS*DUTY_W-1:0]   duty_out,
    output logic [CHANNELS*4-1:0]        duty_be,
    output logic [PERIOD_W-1:0]          period_out,
    output logic                         irq
);
    // One extra bit over the widest operand so gaps and sums never wrap.
    localparam int MATH_W = ((DUTY_W > 8) ? DUTY_W : 8) + 1;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PRESC  = 4'd1;
    localparam logic [3:0] ADDR_PERIOD = 4'd2;
    localparam logic [3:0] ADDR_STATUS = 4'd3;

    logic                      enable_q, enable_d;
    logic [7:0]                step_q, step_d;
    logic [PRESC_W-1:0]        presc_q, presc_d;
    logic [PRESC_W-1:0]        cnt_q, cnt_d;
    logic [PERIOD_W-1:0]       period_q, period_d;
    logic [31:0]               rd_data_q, rd_data_d;

    logic [31:0]               wmask;
    logic [31:0]               rd_word;
    logic                      tick;
    logic [7:0]                step_eff;
    logic [CHANNELS-1:0]       status_clr;
    logic [CHANNELS-1:0]       done_vec;
    logic [CHANNELS-1:0]       busy_vec;
    logic [CHANNELS*DUTY_W-1:0] target_vec;
    logic [CHANNELS*DUTY_W-1:0] current_vec;

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [31:0] mask);
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    assign wmask    = {{8{byteenable[3]}}, {8{byteenable[2]}},
                       {8{byteenable[1]}}, {8{byteenable[0]}}};
    assign tick     = enable_q && (cnt_q == presc_q);
    assign step_eff = (step_q == 8'd0) ? 8'd1 : step_q;

    assign status_clr = (wr_en && addr == ADDR_STATUS && byteenable[0])
                        ? wr_data[CHANNELS-1:0] : '0;

    always_comb begin
        enable_d = enable_q;
        step_d   = step_q;
        presc_d  = presc_q;
        period_d = period_q;
        // Disabled prescaler parks at zero so re-enable gives a full interval.
        cnt_d    = (!enable_q || tick) ? '0 : cnt_q + PRESC_W'(1);

        if (wr_en) begin
            case (addr)
                ADDR_CTRL: begin
                    enable_d = byteenable[0] ? wr_data[0]    : enable_q;
                    step_d   = byteenable[1] ? wr_data[15:8] : step_q;
                end
                ADDR_PRESC:  presc_d  = PRESC_W'(merge(32'(presc_q), wr_data, wmask));
                ADDR_PERIOD: period_d = PERIOD_W'(merge(32'(period_q), wr_data, wmask));
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        case (addr)
            ADDR_CTRL:   rd_word = {16'b0, step_q, 7'b0, enable_q};
            ADDR_PRESC:  rd_word = 32'(presc_q);
            ADDR_PERIOD: rd_word = 32'(period_q);
            ADDR_STATUS: begin
                rd_word[CHANNELS-1:0]   = done_vec;
                rd_word[16 +: CHANNELS] = busy_vec;
            end
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (addr == 4'(4 + i)) begin
                        rd_word = {16'b0,
                                   8'(current_vec[i*DUTY_W +: DUTY_W]),
                                   8'(target_vec[i*DUTY_W +: DUTY_W])};
                    end
                end
            end
        endcase
        rd_data_d = rd_en ? rd_word : rd_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q  <= 1'b0;
            step_q    <= 8'd1;
            presc_q   <= '0;
            cnt_q     <= '0;
            period_q  <= PERIOD_W'(255);
            rd_data_q <= '0;
        end else begin
            enable_q  <= enable_d;
            step_q    <= step_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            rd_data_q <= rd_data_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        localparam logic [3:0] TGT_ADDR = 4'(4 + gi);

        logic [DUTY_W-1:0] target_q, target_d;
        logic [DUTY_W-1:0] current_q, current_d;
        logic              done_q, done_d;
        logic              be_q, be_d;
        logic [MATH_W-1:0] cur_x, tgt_x, stp_x, gap;
        logic              step_hit;

        always_comb begin
            cur_x     = MATH_W'(current_q);
            tgt_x     = MATH_W'(target_q);
            stp_x     = MATH_W'(step_eff);
            gap       = '0;
            current_d = current_q;
            be_d      = 1'b0;
            step_hit  = 1'b0;
            target_d  = target_q;

            if (wr_en && addr == TGT_ADDR) begin
                target_d = DUTY_W'(merge(32'(target_q), wr_data, wmask));
            end

            // The step always uses the pre-write target; a new target lands next tick.
            if (tick && current_q != target_q) begin
                be_d = 1'b1;
                if (tgt_x > cur_x) begin
                    gap       = tgt_x - cur_x;
                    current_d = (gap <= stp_x) ? target_q : DUTY_W'(cur_x + stp_x);
                end else begin
                    gap       = cur_x - tgt_x;
                    current_d = (gap <= stp_x) ? target_q : DUTY_W'(cur_x - stp_x);
                end
                step_hit = (gap <= stp_x);
            end

            done_d = (done_q & ~status_clr[gi]) | step_hit;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                target_q  <= '0;
                current_q <= '0;
                done_q    <= 1'b0;
                be_q      <= 1'b0;
            end else begin
                target_q  <= target_d;
                current_q <= current_d;
                done_q    <= done_d;
                be_q      <= be_d;
            end
        end

        assign duty_out[gi*DUTY_W +: DUTY_W]    = current_q;
        assign duty_be[gi*4 +: 4]               = {3'b000, be_q};
        assign target_vec[gi*DUTY_W +: DUTY_W]  = target_q;
        assign current_vec[gi*DUTY_W +: DUTY_W] = current_q;
        assign done_vec[gi]                     = done_q;
        assign busy_vec[gi]                     = (current_q != target_q);
    end

    assign rd_data    = rd_data_q;
    assign period_out = period_q;
    assign irq        = |done_vec;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer: bus access, ramps, freeze, W1C races,
// byte lanes and asynchronous reset during a fade.
`timescale 1ns/1ps
module tb_pwm_fade_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] rd_data;
    logic [31:0] duty_out;
    logic [15:0] duty_be;
    logic [8:0]  period_out;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    pwm_fade_sequencer #(
        .CHANNELS(4), .DUTY_W(8), .PERIOD_W(9), .PRESC_W(16)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .byteenable(byteenable), .rd_data(rd_data),
        .duty_out(duty_out), .duty_be(duty_be), .period_out(period_out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; addr = a; wr_data = d; byteenable = be;
        @(posedge clk);
        #1;
        wr_en = 1'b0; byteenable = 4'd0;
        $display("wr addr=%0d data=%h be=%b", a, d, be);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        rd_en = 1'b1; addr = a;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        d = rd_data;
        $display("rd addr=%0d data=%h", a, d);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0;
        cycles(3);
        vectors++; if (duty_out !== 32'h0) begin miscompares++; $display("FAIL reset_duty got=%h exp=%h", duty_out, 32'h0); end
        vectors++; if (duty_be !== 16'h0) begin miscompares++; $display("FAIL reset_be got=%h exp=%h", duty_be, 16'h0); end
        vectors++; if (period_out !== 9'd255) begin miscompares++; $display("FAIL reset_period got=%h exp=%h", period_out, 9'd255); end
        vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd got=%h exp=%h", rd_data, 32'h0); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(negedge clk) reset = 1'b1;
        cycles(1);
        bus_read(4'd2, d);
        vectors++; if (d !== 32'h0000_00FF) begin miscompares++; $display("FAIL rd_period got=%h exp=%h", d, 32'hFF); end
        bus_read(4'd4, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rd_target0 got=%h exp=%h", d, 32'h0); end
        bus_read(4'd3, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rd_status_reset got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_ramp();
        logic [31:0] d;
        logic [7:0]  exp;
        bus_write(4'd1, 32'd3, 4'hF);
        bus_write(4'd4, 32'h40, 4'hF);
        bus_write(4'd0, 32'h1001, 4'hF);
        for (int k = 1; k <= 4; k++) begin
            for (int q = 0; q < 3; q++) begin
                cycles(1);
                vectors++; if (duty_be !== 16'h0) begin miscompares++; $display("FAIL ramp_quiet_be step=%0d got=%h exp=0000", k, duty_be); end
            end
            cycles(1);
            exp = 8'(16 * k);
            vectors++; if (duty_out[7:0] !== exp) begin miscompares++; $display("FAIL ramp_duty step=%0d got=%h exp=%h", k, duty_out[7:0], exp); end
            vectors++; if (duty_be !== 16'h0001) begin miscompares++; $display("FAIL ramp_be step=%0d got=%h exp=0001", k, duty_be); end
            vectors++; if (irq !== (k == 4)) begin miscompares++; $display("FAIL ramp_irq step=%0d got=%b exp=%b", k, irq, k == 4); end
        end
        cycles(1);
        vectors++; if (duty_be !== 16'h0) begin miscompares++; $display("FAIL ramp_be_drop got=%h exp=0000", duty_be); end
        bus_read(4'd3, d);
        vectors++; if (d !== 32'h0000_0001) begin miscompares++; $display("FAIL ramp_status got=%h exp=%h", d, 32'h1); end
        bus_read(4'd4, d);
        vectors++; if (d !== 32'h0000_4040) begin miscompares++; $display("FAIL ramp_target_rd got=%h exp=%h", d, 32'h4040); end
    endtask

    task automatic test_underflow();
        logic [31:0] d;
        bus_write(4'd3, 32'h1, 4'hF);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL w1c_irq got=%b exp=0", irq); end
        bus_write(4'd0, 32'h3000, 4'b0011);
        bus_write(4'd4, 32'h05, 4'hF);
        bus_write(4'd0, 32'h3001, 4'b0011);
        cycles(4);
        vectors++; if (duty_out[7:0] !== 8'h10) begin miscompares++; $display("FAIL down_step1 got=%h exp=10", duty_out[7:0]); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL down_irq1 got=%b exp=0", irq); end
        cycles(4);
        vectors++; if (duty_out[7:0] !== 8'h05) begin miscompares++; $display("FAIL down_step2 got=%h exp=05", duty_out[7:0]); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL down_irq2 got=%b exp=1", irq); end
        bus_read(4'd3, d);
        vectors++; if (d !== 32'h0000_0001) begin miscompares++; $display("FAIL down_status got=%h exp=%h", d, 32'h1); end
    endtask

    task automatic test_freeze();
        bus_write(4'd3, 32'h1, 4'hF);
        bus_write(4'd0, 32'h1000, 4'b0011);
        bus_write(4'd4, 32'h85, 4'hF);
        bus_write(4'd6, 32'h30, 4'hF);
        bus_write(4'd0, 32'h1001, 4'b0011);
        cycles(4);
        vectors++; if (duty_out !== 32'h0010_0015) begin miscompares++; $display("FAIL frz_step1 got=%h exp=%h", duty_out, 32'h0010_0015); end
        vectors++; if (duty_be !== 16'h0101) begin miscompares++; $display("FAIL frz_be1 got=%h exp=0101", duty_be); end
        cycles(4);
        vectors++; if (duty_out !== 32'h0020_0025) begin miscompares++; $display("FAIL frz_step2 got=%h exp=%h", duty_out, 32'h0020_0025); end
        bus_write(4'd0, 32'h1000, 4'b0011);
        for (int c = 0; c < 10; c++) begin
            cycles(1);
            vectors++; if (duty_out !== 32'h0020_0025 || duty_be !== 16'h0) begin
                miscompares++; $display("FAIL frz_hold cyc=%0d duty=%h be=%h exp_duty=%h exp_be=0000", c, duty_out, duty_be, 32'h0020_0025);
            end
        end
        bus_write(4'd0, 32'h1001, 4'b0011);
        cycles(3);
        vectors++; if (duty_out !== 32'h0020_0025 || duty_be !== 16'h0) begin miscompares++; $display("FAIL frz_resume_early duty=%h be=%h", duty_out, duty_be); end
        cycles(1);
        vectors++; if (duty_out !== 32'h0030_0035) begin miscompares++; $display("FAIL frz_resume got=%h exp=%h", duty_out, 32'h0030_0035); end
        vectors++; if (duty_be !== 16'h0101) begin miscompares++; $display("FAIL frz_resume_be got=%h exp=0101", duty_be); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL frz_ch2_done got=%b exp=1", irq); end
    endtask

    // Entered one cycle after the resume step of test_freeze; channel 0 steps every 4 clocks.
    task automatic test_w1c_collision();
        logic [31:0] d;
        bus_write(4'd3, 32'h4, 4'hF);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL col_clr2 got=%b exp=0", irq); end
        bus_read(4'd3, d);
        vectors++; if (d !== 32'h0001_0000) begin miscompares++; $display("FAIL col_busy got=%h exp=%h", d, 32'h0001_0000); end
        cycles(17);
        vectors++; if (duty_out[7:0] !== 8'h75) begin miscompares++; $display("FAIL col_pre got=%h exp=75", duty_out[7:0]); end
        bus_write(4'd3, 32'h1, 4'hF);
        vectors++; if (duty_out[7:0] !== 8'h85) begin miscompares++; $display("FAIL col_final got=%h exp=85", duty_out[7:0]); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL col_set_wins got=%b exp=1", irq); end
        bus_read(4'd3, d);
        vectors++; if (d !== 32'h0000_0001) begin miscompares++; $display("FAIL col_status got=%h exp=%h", d, 32'h1); end
        bus_write(4'd3, 32'h1, 4'hF);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL col_w1c got=%b exp=0", irq); end
    endtask

    task automatic test_byteenable();
        logic [31:0] d;
        bus_write(4'd0, 32'h0000_FF01, 4'b0001);
        bus_read(4'd0, d);
        vectors++; if (d !== 32'h0000_1001) begin miscompares++; $display("FAIL be_ctrl got=%h exp=%h", d, 32'h1001); end
        bus_write(4'd15, 32'hFFFF_FFFF, 4'hF);
        bus_read(4'd15, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL be_unmapped got=%h exp=0", d); end
        bus_read(4'd2, d);
        vectors++; if (d !== 32'h0000_00FF) begin miscompares++; $display("FAIL be_period_kept got=%h exp=%h", d, 32'hFF); end
        cycles(2);
        vectors++; if (rd_data !== 32'h0000_00FF) begin miscompares++; $display("FAIL rd_hold got=%h exp=%h", rd_data, 32'hFF); end
        bus_write(4'd2, 32'h0000_01AB, 4'hF);
        vectors++; if (period_out !== 9'h1AB) begin miscompares++; $display("FAIL period_wr got=%h exp=1ab", period_out); end
        bus_write(4'd2, 32'h0000_0000, 4'b0010);
        vectors++; if (period_out !== 9'h0AB) begin miscompares++; $display("FAIL period_lane got=%h exp=0ab", period_out); end
    endtask

    task automatic test_reset_mid_fade();
        logic [31:0] d;
        bus_write(4'd0, 32'h1000, 4'b0011);
        bus_write(4'd5, 32'hF0, 4'hF);
        bus_write(4'd0, 32'h1001, 4'b0011);
        cycles(4);
        vectors++; if (duty_out[15:8] !== 8'h10) begin miscompares++; $display("FAIL mid_pre got=%h exp=10", duty_out[15:8]); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (duty_out !== 32'h0) begin miscompares++; $display("FAIL mid_duty got=%h exp=0", duty_out); end
        vectors++; if (period_out !== 9'd255) begin miscompares++; $display("FAIL mid_period got=%h exp=0ff", period_out); end
        @(negedge clk) reset = 1'b1;
        cycles(8);
        vectors++; if (duty_out !== 32'h0 || duty_be !== 16'h0) begin miscompares++; $display("FAIL mid_idle duty=%h be=%h exp=0", duty_out, duty_be); end
        bus_read(4'd5, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL mid_target got=%h exp=0", d); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_underflow();
        test_freeze();
        test_w1c_collision();
        test_byteenable();
        test_reset_mid_fade();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
